// File: rtl/mips_pkg.sv
// Shared MIPS definitions: MDU operation encodings and default latencies,
// used by the decoder and the multiply/divide unit.
package mips_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101
  } mdu_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  function automatic int max_cycles(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mdu_div.sv
// Combinational 32-bit divider, signed or unsigned, with MIPS-style results
// for divide-by-zero and the 0x80000000 / -1 overflow case.
module mdu_div (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic        neg_q;
  logic        neg_r;

  // Divide magnitudes, then restore signs: quotient truncates toward zero,
  // remainder follows the dividend.
  always_comb begin
    neg_r = is_signed & a[31];
    neg_q = is_signed & (a[31] ^ b[31]);
    mag_a = neg_r ? (32'd0 - a) : a;
    mag_b = (is_signed & b[31]) ? (32'd0 - b) : b;
    q_mag = (mag_b == 32'd0) ? 32'd0 : (mag_a / mag_b);
    r_mag = (mag_b == 32'd0) ? 32'd0 : (mag_a % mag_b);
    quot  = neg_q ? (32'd0 - q_mag) : q_mag;
    rem   = neg_r ? (32'd0 - r_mag) : r_mag;
    if (b == 32'd0) begin
      quot = 32'hFFFF_FFFF;
      rem  = a;
    end else if (is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
      quot = 32'h8000_0000;
      rem  = 32'd0;
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// MIPS HI/LO multiply/divide unit with fixed-latency busy window.
// Define MDU_DIV_EN to include div/divu; otherwise they behave as no-ops.
module mdu_unit
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_W = $clog2(max_cycles(MULT_CYCLES, DIV_CYCLES)) + 1;

  mdu_state_e        state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [31:0]       hi_q, lo_q, shadow_hi, shadow_lo;
  logic [31:0]       res_hi, res_lo;
  logic              capture, commit, write_hi, write_lo;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

`ifdef MDU_DIV_EN
  logic [31:0] div_quot, div_rem;

  mdu_div u_div (
    .a         (A),
    .b         (B),
    .is_signed (MDUOp == MDU_DIV),
    .quot      (div_quot),
    .rem       (div_rem)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MDU_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Results are computed at issue and parked in the shadows; HI/LO only see
  // them when the countdown expires, so software observes the full latency.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    commit     = 1'b0;
    write_hi   = 1'b0;
    write_lo   = 1'b0;
    res_hi     = '0;
    res_lo     = '0;
    case (state)
      MDU_IDLE: begin
        if (start) begin
          case (MDUOp)
            MDU_MULT: begin
              capture    = 1'b1;
              res_hi     = prod_s[63:32];
              res_lo     = prod_s[31:0];
              cnt_next   = CNT_W'(MULT_CYCLES);
              state_next = MDU_BUSY;
            end
            MDU_MULTU: begin
              capture    = 1'b1;
              res_hi     = prod_u[63:32];
              res_lo     = prod_u[31:0];
              cnt_next   = CNT_W'(MULT_CYCLES);
              state_next = MDU_BUSY;
            end
`ifdef MDU_DIV_EN
            MDU_DIV, MDU_DIVU: begin
              capture    = 1'b1;
              res_hi     = div_rem;
              res_lo     = div_quot;
              cnt_next   = CNT_W'(DIV_CYCLES);
              state_next = MDU_BUSY;
            end
`endif
            MDU_MTHI: write_hi = 1'b1;
            MDU_MTLO: write_lo = 1'b1;
            default: ;
          endcase
        end
      end
      MDU_BUSY: begin
        if (cnt == CNT_W'(1)) begin
          commit     = 1'b1;
          cnt_next   = '0;
          state_next = MDU_IDLE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: state_next = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q      <= '0;
      lo_q      <= '0;
      shadow_hi <= '0;
      shadow_lo <= '0;
    end else begin
      if (capture) begin
        shadow_hi <= res_hi;
        shadow_lo <= res_lo;
      end
      if (commit) begin
        hi_q <= shadow_hi;
        lo_q <= shadow_lo;
      end
      if (write_hi) hi_q <= A;
      if (write_lo) lo_q <= A;
    end
  end

  assign busy = (state == MDU_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed scenarios plus randomized ops
// compared against an arithmetic HI/LO model.
module tb_mdu_unit;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  MDUOp = 3'b000;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy;
  logic [31:0] HI, LO;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mdu_unit #(.MULT_CYCLES(MULT_CYC), .DIV_CYCLES(DIV_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .MDUOp(MDUOp),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  function automatic int model_cycles(input logic [2:0] op);
    case (op)
      OP_MULT, OP_MULTU: return MULT_CYC;
      OP_DIV, OP_DIVU:   return DIV_EN ? DIV_CYC : 0;
      default:           return 0;
    endcase
  endfunction

  // Architectural effect of one op on HI/LO, straight from the ISA rules.
  function automatic void model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa = a;
    int sb = b;
    longint p;
    logic [63:0] up;
    case (op)
      OP_MULT: begin
        p = longint'(sa) * longint'(sb);
        exp_hi = p[63:32];
        exp_lo = p[31:0];
      end
      OP_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        exp_hi = up[63:32];
        exp_lo = up[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (DIV_EN) begin
          if (b == 32'd0) begin
            exp_lo = 32'hFFFF_FFFF;
            exp_hi = a;
          end else if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            exp_lo = 32'h8000_0000;
            exp_hi = 32'd0;
          end else if (op == OP_DIV) begin
            exp_lo = 32'(sa / sb);
            exp_hi = 32'(sa % sb);
          end else begin
            exp_lo = a / b;
            exp_hi = a % b;
          end
        end
      end
      OP_MTHI: exp_hi = a;
      OP_MTLO: exp_lo = a;
      default: ;
    endcase
  endfunction

  // Issue one op at a negedge, then count busy cycles and watch that HI/LO
  // hold their pre-op model values; returns at the negedge after busy drops.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output bit held);
    logic [31:0] h0 = exp_hi;
    logic [31:0] l0 = exp_lo;
    start = 1'b1; MDUOp = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom;
    cyc = 0; held = 1'b1;
    while (busy === 1'b1 && cyc < 64) begin
      cyc++;
      if (HI !== h0 || LO !== l0) held = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (HI !== 32'd0) begin n_err++; $display("[TB] FAIL reset_hi: got %h want 0", HI); end
    n_vec++; if (LO !== 32'd0) begin n_err++; $display("[TB] FAIL reset_lo: got %h want 0", LO); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_mult;
    int cyc; bit held;
    run_op(OP_MTHI, 32'h1111_1111, 32'd0, cyc, held); model_apply(OP_MTHI, 32'h1111_1111, 32'd0);
    run_op(OP_MTLO, 32'h2222_2222, 32'd0, cyc, held); model_apply(OP_MTLO, 32'h2222_2222, 32'd0);
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, cyc, held); model_apply(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    n_vec++; if (cyc !== 5) begin n_err++; $display("[TB] FAIL mult_busy_cycles: got %0d want 5", cyc); end
    n_vec++; if (held !== 1'b1) begin n_err++; $display("[TB] FAIL mult_hold: got %b want 1", held); end
    n_vec++; if (HI !== 32'hFFFF_FFFF) begin n_err++; $display("[TB] FAIL mult_hi: got %h want ffffffff", HI); end
    n_vec++; if (LO !== 32'hFFFF_FFFA) begin n_err++; $display("[TB] FAIL mult_lo: got %h want fffffffa", LO); end
  endtask

  task automatic test_multu;
    int cyc; bit held;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, cyc, held); model_apply(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    n_vec++; if (cyc !== 5) begin n_err++; $display("[TB] FAIL multu_busy_cycles: got %0d want 5", cyc); end
    n_vec++; if (held !== 1'b1) begin n_err++; $display("[TB] FAIL multu_hold: got %b want 1", held); end
    n_vec++; if (HI !== 32'd1) begin n_err++; $display("[TB] FAIL multu_hi: got %h want 1", HI); end
    n_vec++; if (LO !== 32'hFFFF_FFFE) begin n_err++; $display("[TB] FAIL multu_lo: got %h want fffffffe", LO); end
  endtask

  task automatic test_div;
    int cyc; bit held;
    int want_cyc = DIV_EN ? 10 : 0;
    logic [31:0] prev_hi = exp_hi;
    logic [31:0] prev_lo = exp_lo;
    logic [31:0] want_hi, want_lo;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, cyc, held); model_apply(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    want_hi = DIV_EN ? 32'hFFFF_FFFF : prev_hi;
    want_lo = DIV_EN ? 32'hFFFF_FFFD : prev_lo;
    n_vec++; if (cyc !== want_cyc) begin n_err++; $display("[TB] FAIL div_busy_cycles: got %0d want %0d", cyc, want_cyc); end
    n_vec++; if (held !== 1'b1) begin n_err++; $display("[TB] FAIL div_hold: got %b want 1", held); end
    n_vec++; if (HI !== want_hi) begin n_err++; $display("[TB] FAIL div_hi: got %h want %h", HI, want_hi); end
    n_vec++; if (LO !== want_lo) begin n_err++; $display("[TB] FAIL div_lo: got %h want %h", LO, want_lo); end

    run_op(OP_DIVU, 32'd7, 32'd0, cyc, held); model_apply(OP_DIVU, 32'd7, 32'd0);
    want_hi = DIV_EN ? 32'd7 : prev_hi;
    want_lo = DIV_EN ? 32'hFFFF_FFFF : prev_lo;
    n_vec++; if (cyc !== want_cyc) begin n_err++; $display("[TB] FAIL divu_zero_busy_cycles: got %0d want %0d", cyc, want_cyc); end
    n_vec++; if (HI !== want_hi) begin n_err++; $display("[TB] FAIL divu_zero_hi: got %h want %h", HI, want_hi); end
    n_vec++; if (LO !== want_lo) begin n_err++; $display("[TB] FAIL divu_zero_lo: got %h want %h", LO, want_lo); end

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, held); model_apply(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    want_hi = DIV_EN ? 32'd0 : prev_hi;
    want_lo = DIV_EN ? 32'h8000_0000 : prev_lo;
    n_vec++; if (HI !== want_hi) begin n_err++; $display("[TB] FAIL div_ovf_hi: got %h want %h", HI, want_hi); end
    n_vec++; if (LO !== want_lo) begin n_err++; $display("[TB] FAIL div_ovf_lo: got %h want %h", LO, want_lo); end
  endtask

  task automatic test_start_while_busy;
    int cyc = 0;
    model_apply(OP_MULT, 32'h0001_0000, 32'h0003_0001);
    start = 1'b1; MDUOp = OP_MULT; A = 32'h0001_0000; B = 32'h0003_0001;
    @(negedge clk);
    start = 1'b0;
    while (busy === 1'b1 && cyc < 64) begin
      cyc++;
      if (cyc == 2) begin start = 1'b1; MDUOp = OP_MTLO; A = 32'd5; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    n_vec++; if (cyc !== 5) begin n_err++; $display("[TB] FAIL stall_busy_cycles: got %0d want 5", cyc); end
    n_vec++; if (LO !== 32'h0001_0000) begin n_err++; $display("[TB] FAIL stall_lo: got %h want 00010000", LO); end
    n_vec++; if (HI !== 32'd3) begin n_err++; $display("[TB] FAIL stall_hi: got %h want 3", HI); end
    @(negedge clk);
    n_vec++; if (LO !== exp_lo) begin n_err++; $display("[TB] FAIL stall_lo_later: got %h want %h", LO, exp_lo); end
  endtask

  task automatic test_reset_mid_op;
    int cyc; bit held; bit clean = 1'b1;
    logic [2:0] op = DIV_EN ? OP_DIV : OP_MULT;
    run_op(OP_MTHI, 32'h0000_AAAA, 32'd0, cyc, held); model_apply(OP_MTHI, 32'h0000_AAAA, 32'd0);
    run_op(OP_MTLO, 32'h0000_BBBB, 32'd0, cyc, held); model_apply(OP_MTLO, 32'h0000_BBBB, 32'd0);
    start = 1'b1; MDUOp = op; A = 32'hFFFF_FFF9; B = 32'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL rst_mid_busy_before: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL rst_mid_busy: got %b want 0", busy); end
    n_vec++; if (HI !== 32'd0) begin n_err++; $display("[TB] FAIL rst_mid_hi: got %h want 0", HI); end
    n_vec++; if (LO !== 32'd0) begin n_err++; $display("[TB] FAIL rst_mid_lo: got %h want 0", LO); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_hi = '0; exp_lo = '0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) clean = 1'b0;
    end
    n_vec++; if (clean !== 1'b1) begin n_err++; $display("[TB] FAIL rst_mid_no_commit: got %b want 1 (HI=%h LO=%h)", clean, HI, LO); end
  endtask

  task automatic test_mthi_mtlo;
    bit saw_busy = 1'b0;
    start = 1'b1; MDUOp = OP_MTHI; A = 32'h0000_1234;
    @(negedge clk);
    if (busy !== 1'b0) saw_busy = 1'b1;
    n_vec++; if (HI !== 32'h0000_1234) begin n_err++; $display("[TB] FAIL mthi_hi: got %h want 00001234", HI); end
    n_vec++; if (LO !== 32'd0) begin n_err++; $display("[TB] FAIL mthi_lo_kept: got %h want 0", LO); end
    MDUOp = OP_MTLO; A = 32'h0000_5678;
    @(negedge clk);
    start = 1'b0;
    if (busy !== 1'b0) saw_busy = 1'b1;
    model_apply(OP_MTHI, 32'h0000_1234, 32'd0);
    model_apply(OP_MTLO, 32'h0000_5678, 32'd0);
    n_vec++; if (HI !== 32'h0000_1234) begin n_err++; $display("[TB] FAIL mtlo_hi_kept: got %h want 00001234", HI); end
    n_vec++; if (LO !== 32'h0000_5678) begin n_err++; $display("[TB] FAIL mtlo_lo: got %h want 00005678", LO); end
    n_vec++; if (saw_busy !== 1'b0) begin n_err++; $display("[TB] FAIL mthi_mtlo_busy: got %b want 0", saw_busy); end
  endtask

  task automatic test_undefined;
    int cyc; bit held;
    logic [31:0] h0, l0;
    for (int op = 6; op < 8; op++) begin
      h0 = exp_hi; l0 = exp_lo;
      run_op(3'(op), $urandom, $urandom, cyc, held);
      n_vec++; if (cyc !== 0) begin n_err++; $display("[TB] FAIL undef_busy op=%0d: got %0d want 0", op, cyc); end
      n_vec++; if (HI !== h0 || LO !== l0) begin n_err++; $display("[TB] FAIL undef_hilo op=%0d: got %h/%h want %h/%h", op, HI, LO, h0, l0); end
    end
  endtask

  task automatic test_random;
    int cyc; bit held;
    logic [2:0] op;
    logic [31:0] a, b;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9)) * (($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1);
        default: ;
      endcase
      run_op(op, a, b, cyc, held);
      model_apply(op, a, b);
      n_vec++; if (cyc !== model_cycles(op)) begin n_err++; $display("[TB] FAIL rand_busy op=%0d: got %0d want %0d", op, cyc, model_cycles(op)); end
      n_vec++; if (held !== 1'b1) begin n_err++; $display("[TB] FAIL rand_hold op=%0d: got %b want 1", op, held); end
      n_vec++; if (HI !== exp_hi) begin n_err++; $display("[TB] FAIL rand_hi op=%0d a=%h b=%h: got %h want %h", op, a, b, HI, exp_hi); end
      n_vec++; if (LO !== exp_lo) begin n_err++; $display("[TB] FAIL rand_lo op=%0d a=%h b=%h: got %h want %h", op, a, b, LO, exp_lo); end
      if ($urandom_range(0, 1) != 0) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_start_while_busy();
    test_reset_mid_op();
    test_mthi_mtlo();
    test_undefined();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: cycles busy is held for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: cycles busy is held for div/divu.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request qualifier for MDUOp.
REQ-006 MDUOp  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, others no-op.
REQ-007 A  input  32  operand (dividend / multiplicand / mthi-mtlo source).
REQ-008 B  input  32  operand (divisor / multiplier).
REQ-009 busy  output  1  operation in flight; high while results are pending.
REQ-010 HI  output  32  architectural HI register.
REQ-011 LO  output  32  architectural LO register.

Function
REQ-012 SHALL implement FSM with states IDLE and BUSY, plus a down-counter of width clog2(max(MULT_CYCLES,DIV_CYCLES))+1.
REQ-013 In IDLE with start=1 and MDUOp mult/multu/div/divu: SHALL capture the result into shadow registers at that edge, load counter with the op's cycle count, enter BUSY.
REQ-014 busy SHALL be high for exactly the configured cycle count, starting the cycle after the start edge.
REQ-015 In BUSY the counter SHALL decrement each cycle; on the cycle it reaches 1, the next edge SHALL commit shadow to HI/LO and return to IDLE (busy low that cycle onward).
REQ-016 HI/LO SHALL hold their old values throughout BUSY.
REQ-017 start while busy=1 SHALL be ignored (no state change); issuing unit must stall.
REQ-018 mthi/mtlo with start=1 in IDLE SHALL write A to HI/LO at that edge, no busy.
REQ-019 mult: signed 32x32 product, HI=bits[63:32], LO=bits[31:0]; multu: unsigned likewise.
REQ-020 div: LO=quotient truncated toward zero, HI=remainder with sign of dividend; divu unsigned.
REQ-021 div 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-022 Divide by zero (div or divu) SHALL give LO=0xFFFFFFFF, HI=A, with normal busy timing.
REQ-023 Undefined MDUOp with start=1 SHALL be a no-op.

Reset
REQ-024 rst_n low SHALL immediately clear HI, LO, shadows and counter to 0, state to IDLE, busy to 0.
REQ-025 Reset mid-operation SHALL discard the pending result; HI/LO remain 0 after release.

Configuration
REQ-026 Macro MDU_DIV_EN defined: div/divu SHALL be supported as above.
REQ-027 MDU_DIV_EN undefined: div/divu SHALL be no-ops (no busy, HI/LO unchanged) and no divider logic synthesised.

Structure
REQ-028 MDUOp encodings and default cycle constants SHALL live in shared package mips_pkg, also used by the decoder.
REQ-029 One sub-module mdu_div (combinational signed/unsigned divide with zero and overflow handling) SHALL be instantiated only under MDU_DIV_EN.

Verification
REQ-030 mult A=0xFFFFFFFE B=3 -> busy 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFA.
REQ-031 multu A=0xFFFFFFFF B=2 -> HI=1 LO=0xFFFFFFFE after 5 cycles; HI/LO unchanged during busy.
REQ-032 div A=-7 B=2 -> busy 10 cycles, LO=0xFFFFFFFD HI=0xFFFFFFFF; divu A=7 B=0 -> LO=0xFFFFFFFF HI=7.
REQ-033 mult issued, second start (mtlo A=5) at busy cycle 2 -> ignored, final LO is the mult result.
REQ-034 rst_n pulsed low at busy cycle 3 of div -> busy=0 immediately, HI=LO=0, no later commit.
REQ-035 mthi A=0x1234 then mtlo A=0x5678 back-to-back -> HI=0x1234 LO=0x5678, busy never asserted.
